// File: rtl/fir_out_requant.sv
// Requantizes the 32-bit FIR output to 16 bits (round half-up, saturate), optionally decimates, and buffers into a FWFT FIFO.
// Optional macro REQUANT_SATCNT_EN adds a saturating 16-bit count of saturation events on port sat_cnt.
module fir_out_requant #(
    parameter int IN_W       = 32,
    parameter int OUT_W      = 16,
    parameter int SHIFT      = 15,
    parameter int DECIM      = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    input  logic [IN_W-1:0]               in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OUT_W-1:0]              out_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          drop_err
`ifdef REQUANT_SATCNT_EN
    ,
    output logic [15:0]                   sat_cnt
`endif
);

    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int LW     = AW + 1;
    localparam int DCNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;

    localparam logic [DCNT_W-1:0] DCNT_LAST  = DCNT_W'(DECIM - 1);
    localparam logic [LW-1:0]     LEVEL_FULL = LW'(FIFO_DEPTH);
    localparam logic signed [IN_W:0] RND     = $signed({{IN_W{1'b0}}, 1'b1} << (SHIFT - 1));
    localparam logic signed [IN_W:0] SAT_MAX = $signed({{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}});
    localparam logic signed [IN_W:0] SAT_MIN = $signed({{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}});

    logic signed [IN_W:0] sum_s;
    logic signed [IN_W:0] shr_s;
    logic [OUT_W-1:0]     rq_s;

    logic                 s1_valid_q, s1_valid_d;
    logic [OUT_W-1:0]     s1_data_q,  s1_data_d;
    logic [DCNT_W-1:0]    dcnt_q,     dcnt_d;
    logic [AW-1:0]        wr_ptr_q,   wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q,   rd_ptr_d;
    logic [LW-1:0]        level_q,    level_d;
    logic                 drop_q,     drop_d;
    logic                 out_valid_q, out_valid_d;
    logic [OUT_W-1:0]     out_data_q,  out_data_d;
    logic [OUT_W-1:0]     mem_q [FIFO_DEPTH];
    logic [OUT_W-1:0]     mem_d [FIFO_DEPTH];

    logic keep_s, full_s, pop_s, push_s, drop_s;

    // Round and saturate; one extra bit keeps the rounding add from overflowing.
    always_comb begin
        sum_s = $signed({in_data[IN_W-1], in_data}) + RND;
        shr_s = sum_s >>> SHIFT;
        if (shr_s > SAT_MAX) begin
            rq_s = {1'b0, {(OUT_W-1){1'b1}}};
        end else if (shr_s < SAT_MIN) begin
            rq_s = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            rq_s = shr_s[OUT_W-1:0];
        end
    end

    // Stage-1 register inputs and decimation counter.
    always_comb begin
        s1_valid_d = in_valid;
        if (in_valid) begin
            s1_data_d = rq_s;
        end else begin
            s1_data_d = s1_data_q;
        end
        if (s1_valid_q) begin
            if (dcnt_q == DCNT_LAST) begin
                dcnt_d = {DCNT_W{1'b0}};
            end else begin
                dcnt_d = dcnt_q + {{(DCNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            dcnt_d = dcnt_q;
        end
    end

    assign keep_s = s1_valid_q && (dcnt_q == {DCNT_W{1'b0}});
    assign full_s = (level_q == LEVEL_FULL);
    assign pop_s  = out_valid_q && out_ready;
    assign push_s = keep_s && (!full_s || pop_s);
    assign drop_s = keep_s && full_s && !pop_s;

    // FIFO pointers, occupancy, storage and the registered head word.
    always_comb begin
        wr_ptr_d = push_s ? (wr_ptr_q + {{(AW-1){1'b0}}, 1'b1}) : wr_ptr_q;
        rd_ptr_d = pop_s  ? (rd_ptr_q + {{(AW-1){1'b0}}, 1'b1}) : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   level_d = level_q + {{(LW-1){1'b0}}, 1'b1};
            2'b01:   level_d = level_q - {{(LW-1){1'b0}}, 1'b1};
            default: level_d = level_q;
        endcase
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_d[i] = (push_s && (wr_ptr_q == AW'(i))) ? s1_data_q : mem_q[i];
        end
        drop_d      = drop_q | drop_s;
        out_valid_d = (level_d != {LW{1'b0}});
        out_data_d  = mem_d[rd_ptr_d];
    end

    // State registers; reset clears all buffered data at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_data_q   <= {OUT_W{1'b0}};
            dcnt_q      <= {DCNT_W{1'b0}};
            wr_ptr_q    <= {AW{1'b0}};
            rd_ptr_q    <= {AW{1'b0}};
            level_q     <= {LW{1'b0}};
            drop_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= {OUT_W{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= {OUT_W{1'b0}};
            end
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            dcnt_q      <= dcnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            drop_q      <= drop_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign fifo_level = level_q;
    assign drop_err   = drop_q;

`ifdef REQUANT_SATCNT_EN
    logic        sat_s;
    logic [15:0] sat_cnt_q, sat_cnt_d;

    assign sat_s = (shr_s > SAT_MAX) || (shr_s < SAT_MIN);

    // Counts every saturated input, before decimation or FIFO drops.
    always_comb begin
        if (in_valid && sat_s && (sat_cnt_q != 16'hFFFF)) begin
            sat_cnt_d = sat_cnt_q + 16'd1;
        end else begin
            sat_cnt_d = sat_cnt_q;
        end
    end

    // Saturation counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt_q <= 16'd0;
        end else begin
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign sat_cnt = sat_cnt_q;
`endif

endmodule

// File: tb/tb_fir_out_requant.sv
// Self-checking bench for fir_out_requant: a DECIM=1 instance for rounding/saturation/FIFO, a DECIM=4 instance for decimation.
module tb_fir_out_requant;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, out_valid, out_ready, drop_err;
    logic [31:0] in_data;
    logic [15:0] out_data;
    logic [2:0]  fifo_level;
    logic        in_valid4, out_valid4, out_ready4, drop_err4;
    logic [31:0] in_data4;
    logic [15:0] out_data4;
    logic [2:0]  fifo_level4;
`ifdef REQUANT_SATCNT_EN
    logic [15:0] sat_cnt, sat_cnt4;
    int          sat_exp = 0;
`endif

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp4_q[$];

    always #5 clk = ~clk;

    fir_out_requant #(.IN_W(32), .OUT_W(16), .SHIFT(15), .DECIM(1), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .fifo_level(fifo_level), .drop_err(drop_err)
`ifdef REQUANT_SATCNT_EN
        , .sat_cnt(sat_cnt)
`endif
    );

    fir_out_requant #(.IN_W(32), .OUT_W(16), .SHIFT(15), .DECIM(4), .FIFO_DEPTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_data(in_data4),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
        .fifo_level(fifo_level4), .drop_err(drop_err4)
`ifdef REQUANT_SATCNT_EN
        , .sat_cnt(sat_cnt4)
`endif
    );

    // Reference requantizer: {sat, value} for SHIFT=15, OUT_W=16.
    function automatic logic [16:0] model(input logic [31:0] x);
        longint v;
        longint r;
        v = longint'($signed(x));
        r = (v + 64'sd16384) >>> 15;
        if (r > 64'sd32767) return {1'b1, 16'h7FFF};
        else if (r < -64'sd32768) return {1'b1, 16'h8000};
        else return {1'b0, r[15:0]};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b0;
        in_valid4 = 1'b0; in_data4 = 32'd0; out_ready4 = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || out_data !== 16'd0 || fifo_level !== 3'd0 || drop_err !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: valid=%b data=%h level=%0d drop=%b, required 0/0000/0/0",
                     out_valid, out_data, fifo_level, drop_err);
        end
`ifdef REQUANT_SATCNT_EN
        n_cmp++;
        if (sat_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL reset_satcnt: got %0d required 0", sat_cnt);
        end
`endif
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_rounding();
        int          ins [5] = '{3276800, 3293184, 3293183, -16384, -16385};
        logic [15:0] outs[5] = '{16'd100, 16'd101, 16'd100, 16'h0000, 16'hFFFF};
        logic [15:0] e;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = ins[i];
            exp_q.push_back(outs[i]);
            @(negedge clk);
            in_valid = 1'b0;
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL round_latency1[%0d]: out_valid=%b required 0", i, out_valid);
            end
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== e) begin
                n_err++;
                $display("FAIL round_out[%0d]: valid=%b data=%0d, required 1/%0d",
                         i, out_valid, $signed(out_data), $signed(e));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_saturation();
        // 1073725440 is exactly 32767.5 LSB: half-up gives 32768, so it clips (a sat event).
        logic [31:0] vals[4] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'd1073725440, 32'd1073725439};
        logic [16:0] m;
        logic [15:0] e;
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (out_valid && out_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL sat_unexpected: got %0d required no output", $signed(out_data));
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e) begin
                        n_err++;
                        $display("FAIL sat_out: got %0d required %0d", $signed(out_data), $signed(e));
                    end
                end
            end
            if (c < 4) begin
                in_valid = 1'b1; in_data = vals[c];
                m = model(vals[c]);
                exp_q.push_back(m[15:0]);
`ifdef REQUANT_SATCNT_EN
                sat_exp += int'(m[16]);
`endif
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL sat_timeout: %0d outputs missing, required 0", exp_q.size());
            exp_q.delete();
        end
`ifdef REQUANT_SATCNT_EN
        n_cmp++;
        if (int'(sat_cnt) != sat_exp) begin
            n_err++;
            $display("FAIL sat_cnt: got %0d required %0d", sat_cnt, sat_exp);
        end
`endif
    endtask

    task automatic test_overflow();
        int          mlevel = 0;
        logic [15:0] e;
        out_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            in_valid = 1'b1; in_data = 32'(k * 32768);
            if (mlevel < 4) begin
                exp_q.push_back(16'(k));
                mlevel++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (fifo_level !== 3'd4 || drop_err !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_full: level=%0d drop=%b required 4/1", fifo_level, drop_err);
        end
        for (int h = 0; h < 2; h++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== exp_q[0]) begin
                n_err++;
                $display("FAIL ovf_hold[%0d]: valid=%b data=%0d required 1/%0d", h, out_valid, out_data, exp_q[0]);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (out_valid && out_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL ovf_extra: got %0d required no output", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e) begin
                        n_err++;
                        $display("FAIL ovf_drain: got %0d required %0d", out_data, e);
                    end
                end
            end
            @(negedge clk);
        end
        n_cmp++;
        if (exp_q.size() != 0 || drop_err !== 1'b1 || fifo_level !== 3'd0) begin
            n_err++;
            $display("FAIL ovf_after: left=%0d drop=%b level=%0d required 0/1/0", exp_q.size(), drop_err, fifo_level);
            exp_q.delete();
        end
    endtask

    task automatic test_full_push_pop();
        logic [15:0] e;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b0;
        for (int k = 2; k <= 5; k++) begin
            in_valid = 1'b1; in_data = 32'(k * 32768);
            exp_q.push_back(16'(k));
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        in_valid = 1'b1; in_data = 32'(6 * 32768);
        exp_q.push_back(16'd6);
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        e = exp_q.pop_front();
        n_cmp++;
        if (fifo_level !== 3'd4 || out_data !== e) begin
            n_err++;
            $display("FAIL fpp_pre: level=%0d head=%0d required 4/%0d", fifo_level, out_data, e);
        end
        @(negedge clk);
        out_ready = 1'b0;
        n_cmp++;
        if (fifo_level !== 3'd4 || drop_err !== 1'b0) begin
            n_err++;
            $display("FAIL fpp_level: level=%0d drop=%b required 4/0", fifo_level, drop_err);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (out_valid && out_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL fpp_extra: got %0d required no output", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e) begin
                        n_err++;
                        $display("FAIL fpp_drain: got %0d required %0d", out_data, e);
                    end
                end
            end
            @(negedge clk);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL fpp_timeout: %0d outputs missing, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_decimation();
        logic [15:0] e;
        out_ready4 = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            for (int c = 0; c < 65; c++) begin
                if (out_valid4 && out_ready4) begin
                    n_cmp++;
                    if (exp4_q.size() == 0) begin
                        n_err++;
                        $display("FAIL decim_extra: got %0d required no output", out_data4);
                    end else begin
                        e = exp4_q.pop_front();
                        if (out_data4 !== e) begin
                            n_err++;
                            $display("FAIL decim_out: got %0d required %0d", out_data4, e);
                        end
                    end
                end
                if (c == 0) begin
                    in_valid4 = 1'b1; in_data4 = 32'(k * 32768);
                    if ((k - 1) % 4 == 0) exp4_q.push_back(16'(k));
                end else begin
                    in_valid4 = 1'b0;
                end
                @(negedge clk);
            end
        end
        n_cmp++;
        if (exp4_q.size() != 0) begin
            n_err++;
            $display("FAIL decim_timeout: %0d outputs missing, required 0", exp4_q.size());
            exp4_q.delete();
        end
    endtask

    task automatic test_reset_midstream();
        logic [15:0] e;
        out_ready = 1'b0;
        for (int k = 7; k <= 11; k++) begin
            in_valid = 1'b1; in_data = 32'(k * 32768);
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        out_ready = 1'b1;
        n_cmp++;
        if (out_data !== 16'd7) begin
            n_err++;
            $display("FAIL mid_head: got %0d required 7", out_data);
        end
        @(negedge clk);
        out_ready = 1'b0;
        n_cmp++;
        if (fifo_level !== 3'd3 || drop_err !== 1'b1) begin
            n_err++;
            $display("FAIL mid_pre: level=%0d drop=%b required 3/1", fifo_level, drop_err);
        end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || fifo_level !== 3'd0 || drop_err !== 1'b0 || out_data !== 16'd0) begin
            n_err++;
            $display("FAIL mid_async: valid=%b level=%0d drop=%b data=%0d required 0/0/0/0",
                     out_valid, fifo_level, drop_err, out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1; out_ready4 = 1'b1;
        in_valid = 1'b1; in_data = 32'(12 * 32768);
        in_valid4 = 1'b1; in_data4 = 32'(11 * 32768);
        exp_q.push_back(16'd12);
        exp4_q.push_back(16'd11);
        @(negedge clk);
        in_valid = 1'b0; in_valid4 = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (out_valid && out_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL mid_extra: got %0d required no output", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e) begin
                        n_err++;
                        $display("FAIL mid_out: got %0d required %0d", out_data, e);
                    end
                end
            end
            if (out_valid4 && out_ready4) begin
                n_cmp++;
                if (exp4_q.size() == 0) begin
                    n_err++;
                    $display("FAIL mid4_extra: got %0d required no output", out_data4);
                end else begin
                    e = exp4_q.pop_front();
                    if (out_data4 !== e) begin
                        n_err++;
                        $display("FAIL mid4_out: got %0d required %0d", out_data4, e);
                    end
                end
            end
            @(negedge clk);
        end
        n_cmp++;
        if (exp_q.size() != 0 || exp4_q.size() != 0) begin
            n_err++;
            $display("FAIL mid_timeout: missing %0d/%0d outputs, required 0/0", exp_q.size(), exp4_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_rounding();
        test_saturation();
        test_overflow();
        test_full_push_pop();
        test_decimation();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
